// File: rtl/bus_arbiter.sv
// Two-master bus arbiter (CPU vs DMA) with round-robin tie break and a
// hold-count quantum that preempts an owner only while the other side waits.
module bus_arbiter #(
    parameter int QUANTUM = 16
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       dma_req,
    output logic       cpu_gnt,
    output logic       dma_gnt,
    output logic [1:0] owner,
    output logic       preempt
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] GNT_CPU = 2'b01;
    localparam logic [1:0] GNT_DMA = 2'b10;

    localparam logic [7:0] QUANTUM_CNT = 8'(QUANTUM);

    logic [1:0] state;
    logic [1:0] next_state;
    logic [7:0] hold_cnt;
    logic       last_dma;
    logic       preempt_next;
    logic       grant_entry;

    // Release is tested before the quantum so a simultaneous drop never
    // reports a preemption.
    always_comb begin
        next_state   = state;
        preempt_next = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && dma_req)
                    next_state = last_dma ? GNT_CPU : GNT_DMA;
                else if (cpu_req)
                    next_state = GNT_CPU;
                else if (dma_req)
                    next_state = GNT_DMA;
            end
            GNT_CPU: begin
                if (!cpu_req) begin
                    next_state = IDLE;
                end else if (hold_cnt == QUANTUM_CNT && dma_req) begin
                    next_state   = IDLE;
                    preempt_next = 1'b1;
                end
            end
            GNT_DMA: begin
                if (!dma_req) begin
                    next_state = IDLE;
                end else if (hold_cnt == QUANTUM_CNT && cpu_req) begin
                    next_state   = IDLE;
                    preempt_next = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign grant_entry = (state == IDLE) && (next_state != IDLE);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            preempt <= 1'b0;
        end else begin
            state   <= next_state;
            preempt <= preempt_next;
        end
    end

    // The counter reads 1 during the first grant cycle and sticks at 255.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)
            hold_cnt <= 8'd0;
        else if (grant_entry)
            hold_cnt <= 8'd1;
        else if (next_state == IDLE)
            hold_cnt <= 8'd0;
        else if (hold_cnt != 8'hFF)
            hold_cnt <= hold_cnt + 8'd1;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)
            last_dma <= 1'b1;
        else if (grant_entry)
            last_dma <= (next_state == GNT_DMA);
    end

    assign cpu_gnt = (state == GNT_CPU);
    assign dma_gnt = (state == GNT_DMA);
    assign owner   = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a QUANTUM=4 instance for the main sequence
// and a QUANTUM=1 instance for strict alternation.
module tb_bus_arbiter;

    logic       sys_clk;
    logic       reset;
    logic       cpu_req;
    logic       dma_req;
    logic       cpu_gnt;
    logic       dma_gnt;
    logic [1:0] owner;
    logic       preempt;

    logic       q1_cpu_req;
    logic       q1_dma_req;
    logic       q1_cpu_gnt;
    logic       q1_dma_gnt;
    logic [1:0] q1_owner;
    logic       q1_preempt;

    int vectors     = 0;
    int miscompares = 0;
    int violations  = 0;

    logic [1:0] prev_owner    = 2'b00;
    logic [1:0] q1_prev_owner = 2'b00;

    bus_arbiter #(.QUANTUM(4)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .cpu_req (cpu_req),
        .dma_req (dma_req),
        .cpu_gnt (cpu_gnt),
        .dma_gnt (dma_gnt),
        .owner   (owner),
        .preempt (preempt)
    );

    bus_arbiter #(.QUANTUM(1)) dut_q1 (
        .sys_clk (sys_clk),
        .reset   (reset),
        .cpu_req (q1_cpu_req),
        .dma_req (q1_dma_req),
        .cpu_gnt (q1_cpu_gnt),
        .dma_gnt (q1_dma_gnt),
        .owner   (q1_owner),
        .preempt (q1_preempt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Mutual exclusion and dead-cycle rule, sampled mid-cycle on both instances.
    always @(negedge sys_clk) begin
        if (cpu_gnt && dma_gnt) violations++;
        if (q1_cpu_gnt && q1_dma_gnt) violations++;
        if (owner == 2'b11 || q1_owner == 2'b11) violations++;
        if (owner != prev_owner && prev_owner != 2'b00 && owner != 2'b00) violations++;
        if (q1_owner != q1_prev_owner && q1_prev_owner != 2'b00 && q1_owner != 2'b00) violations++;
        prev_owner    = owner;
        q1_prev_owner = q1_owner;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkMain(input string tag, input logic c, input logic d, input logic [1:0] o, input logic p);
        checkOutput({tag, ".cpu_gnt"}, {7'd0, cpu_gnt}, {7'd0, c});
        checkOutput({tag, ".dma_gnt"}, {7'd0, dma_gnt}, {7'd0, d});
        checkOutput({tag, ".owner"},   {6'd0, owner},   {6'd0, o});
        checkOutput({tag, ".preempt"}, {7'd0, preempt}, {7'd0, p});
    endtask

    task automatic checkQ1(input string tag, input logic c, input logic d, input logic p);
        checkOutput({tag, ".cpu_gnt"}, {7'd0, q1_cpu_gnt}, {7'd0, c});
        checkOutput({tag, ".dma_gnt"}, {7'd0, q1_dma_gnt}, {7'd0, d});
        checkOutput({tag, ".preempt"}, {7'd0, q1_preempt}, {7'd0, p});
    endtask

    initial begin
        logic saw_preempt;
        logic lost_grant;

        reset      = 1'b1;
        cpu_req    = 1'b0;
        dma_req    = 1'b0;
        q1_cpu_req = 1'b0;
        q1_dma_req = 1'b0;

        // Reset state, held across a clock edge.
        #12;
        checkMain("reset", 1'b0, 1'b0, 2'b00, 1'b0);
        checkOutput("reset.hold_cnt", dut.hold_cnt, 8'd0);
        reset = 1'b0;
        tick();
        checkMain("idle_no_req", 1'b0, 1'b0, 2'b00, 1'b0);

        // Single CPU request, latency one edge, then async reset mid-grant.
        cpu_req = 1'b1;
        tick();
        checkMain("cpu_grant", 1'b1, 1'b0, 2'b01, 1'b0);
        tick();
        tick();
        checkMain("cpu_hold", 1'b1, 1'b0, 2'b01, 1'b0);
        #3 reset = 1'b1;
        #1;
        checkMain("async_reset", 1'b0, 1'b0, 2'b00, 1'b0);
        #2 reset = 1'b0;
        tick();
        checkMain("regrant_after_reset", 1'b1, 1'b0, 2'b01, 1'b0);
        cpu_req = 1'b0;
        tick();
        checkMain("cpu_release", 1'b0, 1'b0, 2'b00, 1'b0);

        // Tie after reset: CPU wins; its release collides with quantum expiry.
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        cpu_req = 1'b1;
        dma_req = 1'b1;
        tick();
        checkMain("tie_edge1", 1'b1, 1'b0, 2'b01, 1'b0);
        tick();
        tick();
        tick();
        checkMain("tie_edge4", 1'b1, 1'b0, 2'b01, 1'b0);
        cpu_req = 1'b0;
        tick();
        checkMain("collision_edge5", 1'b0, 1'b0, 2'b00, 1'b0);
        tick();
        checkMain("dma_after_release", 1'b0, 1'b1, 2'b10, 1'b0);

        // Preemption of DMA: CPU asks during grant cycle 2.
        tick();
        cpu_req = 1'b1;
        tick();
        checkMain("dma_cycle3", 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        checkMain("dma_cycle4", 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        checkMain("dma_preempted", 1'b0, 1'b0, 2'b00, 1'b1);
        tick();
        checkMain("cpu_after_preempt", 1'b1, 1'b0, 2'b01, 1'b0);

        // DMA kept requesting: it is re-granted once CPU is itself preempted.
        tick();
        tick();
        tick();
        checkMain("cpu_cycle4", 1'b1, 1'b0, 2'b01, 1'b0);
        tick();
        checkMain("cpu_preempted", 1'b0, 1'b0, 2'b00, 1'b1);
        tick();
        checkMain("dma_regrant", 1'b0, 1'b1, 2'b10, 1'b0);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();
        checkMain("all_release", 1'b0, 1'b0, 2'b00, 1'b0);

        // No contention: 300 cycles of CPU ownership, counter saturates.
        cpu_req = 1'b1;
        saw_preempt = 1'b0;
        lost_grant  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (preempt) saw_preempt = 1'b1;
            if (!cpu_gnt) lost_grant = 1'b1;
        end
        checkOutput("long_hold.lost_grant", {7'd0, lost_grant}, 8'd0);
        checkOutput("long_hold.preempt_seen", {7'd0, saw_preempt}, 8'd0);
        checkOutput("long_hold.hold_cnt", dut.hold_cnt, 8'd255);
        cpu_req = 1'b0;
        tick();

        // Tie with CPU as most recent owner goes to DMA.
        cpu_req = 1'b1;
        dma_req = 1'b1;
        tick();
        checkMain("tie_after_cpu", 1'b0, 1'b1, 2'b10, 1'b0);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();

        // QUANTUM=1 with both requesting: strict alternation through IDLE.
        q1_cpu_req = 1'b1;
        q1_dma_req = 1'b1;
        tick();
        checkQ1("q1_cpu", 1'b1, 1'b0, 1'b0);
        tick();
        checkQ1("q1_idle1", 1'b0, 1'b0, 1'b1);
        tick();
        checkQ1("q1_dma", 1'b0, 1'b1, 1'b0);
        tick();
        checkQ1("q1_idle2", 1'b0, 1'b0, 1'b1);
        tick();
        checkQ1("q1_cpu_again", 1'b1, 1'b0, 1'b0);
        q1_cpu_req = 1'b0;
        q1_dma_req = 1'b0;
        tick();
        tick();

        checkOutput("monitor.violations", violations[7:0], 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter QUANTUM, default 16, range 1..255: maximum grant cycles before the owner is preempted while the other requester waits.
REQ-002 sys_clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU requests the data-memory/IO bus; held high for the whole access sequence.
REQ-005 dma_req  input  1  DMA engine requests the data-memory/IO bus; held high for the whole transfer.
REQ-006 cpu_gnt  output  1  CPU owns the bus (registered).
REQ-007 dma_gnt  output  1  DMA owns the bus (registered).
REQ-008 owner  output  2  00 none, 01 CPU, 10 DMA; 11 never driven.
REQ-009 preempt  output  1  one-cycle pulse when a grant is forcibly removed by quantum expiry.

Function
REQ-010 The block SHALL implement states IDLE, GNT_CPU and GNT_DMA; cpu_gnt, dma_gnt and owner SHALL be decoded directly from the state register.
REQ-011 cpu_gnt and dma_gnt SHALL never be high in the same cycle.
REQ-012 In IDLE with exactly one req high at a clock edge, the block SHALL enter that requester's GNT state on that edge; grant latency is 1 cycle.
REQ-013 In IDLE with both reqs high, the block SHALL grant the requester that was not granted most recently; the last-owner bit SHALL reset to DMA, so the CPU wins the first tie.
REQ-014 In GNT_x, the block SHALL return to IDLE on the first edge where x_req is low; the released grant SHALL drop on that edge.
REQ-015 Every owner change SHALL pass through IDLE for at least one cycle, which gives one dead bus cycle between owners.
REQ-016 An 8-bit hold counter SHALL load 1 on entry to a GNT state and increment each cycle that state holds, saturating at 255.
REQ-017 In GNT_x, if the counter equals QUANTUM and the other requester's req is high, the block SHALL go to IDLE and pulse preempt for exactly that transition cycle.
REQ-018 The last-owner bit SHALL be updated on every entry to a GNT state; after preemption, REQ-013 therefore grants the waiting requester.
REQ-019 A preempted requester that keeps req high SHALL be re-granted only after the other owner releases or is itself preempted.
REQ-020 If the other req is low, the counter SHALL saturate and the owner SHALL keep the bus indefinitely, with no preempt.
REQ-021 Release (REQ-014) SHALL take precedence over preemption when both conditions hold on the same edge; in that case preempt stays low.
REQ-022 With QUANTUM=1 and both requesters continuously requesting, grants SHALL alternate: one cycle of grant, one IDLE cycle, then the other requester.

Reset
REQ-023 While reset is high, state SHALL be IDLE, cpu_gnt=0, dma_gnt=0, owner=00, preempt=0, counter=0 and last-owner=DMA, independent of sys_clk.
REQ-024 Reset asserted mid-grant SHALL drop the grant asynchronously in the same cycle; after deassertion, arbitration SHALL resume from IDLE on the next edge.

Verification
REQ-025 Reset mid-grant: cpu_req=1 and grant held 3 cycles, assert reset between edges -> cpu_gnt falls immediately; after release, cpu_gnt=1 one edge later.
REQ-026 Tie: both reqs rise together after reset -> cpu_gnt=1 at edge 1; CPU drops req at edge 5 -> IDLE at edge 5, dma_gnt=1 at edge 6, owner=10.
REQ-027 Preemption: QUANTUM=4, DMA granted, cpu_req rises on grant cycle 2 -> at the edge ending cycle 4, dma_gnt=0 and preempt=1 for one cycle; cpu_gnt=1 one edge later.
REQ-028 No contention: QUANTUM=4, cpu_req held 300 cycles, dma_req=0 -> cpu_gnt stays high, counter saturates at 255, preempt never pulses.
REQ-029 Release/preempt collision: QUANTUM=4, owner's req drops on the same edge the counter hits 4 with the other req high -> preempt=0, IDLE, then the other requester is granted.
REQ-030 Assertion check: in all tests, cpu_gnt&dma_gnt is never 1, and every owner change shows owner=00 for at least one cycle.
